// File: rtl/regfile_write_queue.sv
// regfile_write_queue: FIFO of register-file writes draining one entry per cycle; define REGFILE_WQ_FWD_EN to forward pending data to the read path
module regfile_write_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8,
  parameter int REG_W  = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [REG_W-1:0]           in_reg,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       drain_en,
  output logic                       regWrite,
  output logic [REG_W-1:0]           writeReg,
  output logic [DATA_W-1:0]          writeData,
  input  logic [REG_W-1:0]           readReg_1,
  input  logic [REG_W-1:0]           readReg_2,
  input  logic [DATA_W-1:0]          readData_1,
  input  logic [DATA_W-1:0]          readData_2,
  output logic [DATA_W-1:0]          fwdData_1,
  output logic [DATA_W-1:0]          fwdData_2,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  logic [REG_W+DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] wrPtr, rdPtr;
  logic push;
  assign full      = count == (AW+1)'(DEPTH);
  assign empty     = count == '0;
  assign in_ready  = !full;
  assign push      = in_valid && in_ready;
  assign regWrite  = !empty && drain_en;
  assign {writeReg, writeData} = mem[rdPtr];
  // pointers wrap naturally since DEPTH is a power of two; reset wins over push/pop
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wrPtr] <= {in_reg, in_data};
        wrPtr      <= wrPtr + 1'b1;
      end
      if (regWrite) rdPtr <= rdPtr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(regWrite);
    end
  end
`ifdef REGFILE_WQ_FWD_EN
  function automatic logic [DATA_W-1:0] fwd(input logic [REG_W-1:0] r, input logic [DATA_W-1:0] d);
    fwd = d;
    for (int i = 0; i < DEPTH; i++)
      if ((AW+1)'(i) < count && mem[rdPtr + AW'(i)][DATA_W +: REG_W] == r)
        fwd = mem[rdPtr + AW'(i)][DATA_W-1:0];
  endfunction
  // scan oldest to youngest so the youngest matching pending entry wins
  always_comb begin
    fwdData_1 = fwd(readReg_1, readData_1);
    fwdData_2 = fwd(readReg_2, readData_2);
  end
`else
  logic unusedRd;
  assign unusedRd  = ^{readReg_1, readReg_2};
  assign fwdData_1 = readData_1;
  assign fwdData_2 = readData_2;
`endif
endmodule

// File: tb/tb_regfile_write_queue.sv
// tb_regfile_write_queue: scoreboard bench for regfile_write_queue
module tb_regfile_write_queue;
  logic       clk = 0;
  logic       rst = 1;
  logic       in_valid = 0, in_ready;
  logic       in_reg = 0;
  logic [7:0] in_data = 0;
  logic       drain_en = 0;
  logic       regWrite, writeReg;
  logic [7:0] writeData;
  logic       readReg_1 = 0, readReg_2 = 1;
  logic [7:0] readData_1 = 0, readData_2 = 8'h55;
  logic [7:0] fwdData_1, fwdData_2;
  logic [2:0] count;
  logic       full, empty;
  int checks = 0, errors = 0;
  logic [8:0] expQ [$];

  regfile_write_queue dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_reg(in_reg), .in_data(in_data), .drain_en(drain_en),
    .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData),
    .readReg_1(readReg_1), .readReg_2(readReg_2),
    .readData_1(readData_1), .readData_2(readData_2),
    .fwdData_1(fwdData_1), .fwdData_2(fwdData_2),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", n, a, e);
    end
  endtask

  // tracker: record accepted requests, drop everything on reset
  always @(negedge clk) begin
    if (rst) expQ.delete();
    else if (in_valid && in_ready) expQ.push_back({in_reg, in_data});
  end

  // monitor: every commit must match the oldest accepted request
  always @(negedge clk) begin
    if (regWrite && !rst) begin
      if (expQ.size() == 0) chk("unexpected_commit", {writeReg, writeData}, 9'h1ff);
      else chk("commit", {writeReg, writeData}, expQ.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input logic r, input logic [7:0] d);
    int k;
    in_valid = 1; in_reg = r; in_data = d;
    for (k = 0; k < 30; k++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (k == 30) chk("push_timeout", 0, 1);
    tick();
    in_valid = 0;
  endtask

  task automatic drain_wait;
    int k;
    for (k = 0; k < 30 && !empty; k++) @(negedge clk);
    chk("drain_empty", empty, 1);
    tick();
  endtask

  initial begin
    // reset with a request present
    in_valid = 1; in_data = 8'hAA; drain_en = 1;
    tick();
    rst = 0; in_valid = 0;
    @(negedge clk);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_regWrite", regWrite, 0);
    chk("rst_in_ready", in_ready, 1);
    tick();
    // single write
    push1(1, 8'hF0);
    @(negedge clk);
    chk("single_regWrite", regWrite, 1);
    chk("single_writeReg", writeReg, 1);
    chk("single_writeData", writeData, 8'hF0);
    tick();
    @(negedge clk);
    chk("single_empty_after", empty, 1);
    tick();
    // fill and stall
    drain_en = 0;
    for (int i = 1; i <= 4; i++) push1(0, 8'(i));
    @(negedge clk);
    chk("fill_full", full, 1);
    chk("fill_in_ready", in_ready, 0);
    chk("fill_count", count, 4);
    tick();
    in_valid = 1; in_reg = 0; in_data = 8'h05;
    tick(); tick();
    @(negedge clk);
    chk("stall_count", count, 4);
    chk("stall_regWrite", regWrite, 0);
    tick();
    drain_en = 1;
    push1(0, 8'h05);
    drain_wait();
    // steady-state push and pop
    drain_en = 0;
    push1(1, 8'hA0);
    push1(0, 8'hA1);
    drain_en = 1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1; in_reg = 1'(i); in_data = 8'hA2 + 8'(i);
      @(negedge clk);
      chk("steady_count", count, 2);
      tick();
    end
    in_valid = 0;
    drain_wait();
    // forwarding
    drain_en = 0;
    push1(0, 8'h0F);
    push1(0, 8'h3C);
    readReg_1 = 0; readData_1 = 8'h00; readReg_2 = 1; readData_2 = 8'h55;
    @(negedge clk);
`ifdef REGFILE_WQ_FWD_EN
    chk("fwd_data_1", fwdData_1, 8'h3C);
`else
    chk("fwd_data_1", fwdData_1, 8'h00);
`endif
    chk("fwd_data_2_nomatch", fwdData_2, 8'h55);
    tick();
    // reset mid-drain with 3 pending
    push1(1, 8'h77);
    @(negedge clk);
    chk("pre_rst_count", count, 3);
    tick();
    drain_en = 1; rst = 1;
    tick();
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midrst_count", count, 0);
      chk("midrst_regWrite", regWrite, 0);
      chk("midrst_fwd", fwdData_1, 8'h00);
      tick();
    end
    chk("scoreboard_left", expQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
